pipeline_sequencer: RTL and testbench

Sequencing controller for the 4-stage (IF, ID, EX, WB) pipeline. It owns the per-stage valid bits, PC/IF-ID enables, branch squash, RAW-hazard handling (forward or interlock), and the halt-on-illegal-opcode state machine. It consumes decoded ID-stage fields and drives the pipeline-register enables, the operand-forwarding selects and the registered EX/WB control fields that the datapath stages read.

---
 rtl/pipeline_pkg.sv | 48 ++++
 rtl/pipe_hazard_detect.sv | 33 +++
 rtl/pipeline_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared opcode/ALU constants, controller state type and decode helpers for pipeline_sequencer.
package pipeline_pkg;

    localparam int OPC_WIDTH = 2;
    localparam int ALU_WIDTH = 4;

    localparam logic [OPC_WIDTH-1:0] OPC_ADD = 2'b00;
    localparam logic [OPC_WIDTH-1:0] OPC_SHT = 2'b01;
    localparam logic [OPC_WIDTH-1:0] OPC_ILL = 2'b10;
    localparam logic [OPC_WIDTH-1:0] OPC_BR  = 2'b11;

    localparam logic [ALU_WIDTH-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_WIDTH-1:0] ALU_SHL = 4'b1000;
    localparam logic [ALU_WIDTH-1:0] ALU_NOP = 4'b0000;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EX = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    typedef enum logic {S_RUN, S_HALT} state_t;

    function automatic logic opc_writes(input logic [OPC_WIDTH-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SHT);
    endfunction

    function automatic logic opc_reads_rs1(input logic [OPC_WIDTH-1:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SHT);
    endfunction

    function automatic logic opc_reads_rs2(input logic [OPC_WIDTH-1:0] opc);
        return opc == OPC_ADD;
    endfunction

    function automatic logic [ALU_WIDTH-1:0] alu_code(input logic [OPC_WIDTH-1:0] opc);
        case (opc)
            OPC_ADD: return ALU_ADD;
            OPC_SHT: return ALU_SHL;
            OPC_BR:  return ALU_ADD;
            default: return ALU_NOP;
        endcase
    endfunction

    // EX wins over WB because it holds the younger value of the register.
    function automatic logic [1:0] fwd_select(input logic ex_hit, input logic wb_hit);
        return ex_hit ? FWD_EX : (wb_hit ? FWD_WB : FWD_RF);
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational RAW matcher: compares each ID source operand with the live EX and WB destinations.
module pipe_hazard_detect #(
    parameter int REG_W = 3
) (
    input  logic [1:0][REG_W-1:0] i_rs,
    input  logic [1:0]            i_rs_used,
    input  logic                  i_valid_id,
    input  logic [REG_W-1:0]      i_rd_ex,
    input  logic                  i_valid_ex,
    input  logic                  i_wr_ex,
    input  logic [REG_W-1:0]      i_rd_wb,
    input  logic                  i_valid_wb,
    input  logic                  i_wr_wb,
    output logic [1:0]            o_ex_match,
    output logic [1:0]            o_wb_match
);

    logic w_ex_live;
    logic w_wb_live;

    assign w_ex_live = i_valid_ex && i_wr_ex;
    assign w_wb_live = i_valid_wb && i_wr_wb;

    // Register 0 is an ordinary register here, so it is matched like any other.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign o_ex_match[gi] = i_valid_id && i_rs_used[gi] && w_ex_live && (i_rs[gi] == i_rd_ex);
            assign o_wb_match[gi] = i_valid_id && i_rs_used[gi] && w_wb_live && (i_rs[gi] == i_rd_wb);
        end
    endgenerate

endmodule

// File: rtl/pipeline_sequencer.sv
// Sequencing controller for the IF/ID/EX/WB pipeline: valid bits, enables, branch squash,
// RAW interlock and halt-on-illegal. Define FWD_EN to forward operands instead of stalling.
module pipeline_sequencer
    import pipeline_pkg::*;
#(
    parameter int OPC_W   = OPC_WIDTH,
    parameter int REG_W   = 3,
    parameter int ALUOP_W = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_valid,
    input  logic [OPC_W-1:0]   opcode_ID,
    input  logic [REG_W-1:0]   rs1_ID,
    input  logic [REG_W-1:0]   rs2_ID,
    input  logic [REG_W-1:0]   rd_ID,
    input  logic               resume,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               PC_Select,
    output logic               valid_EX,
    output logic               valid_WB,
    output logic [ALUOP_W-1:0] ALU_Operation,
    output logic               RegWrite_WB,
    output logic [REG_W-1:0]   Write_Reg_EX,
    output logic [REG_W-1:0]   Write_Reg_WB,
    output logic [1:0]         fwd_A,
    output logic [1:0]         fwd_B,
    output logic               halted
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_valid_id;
    logic               r_valid_ex;
    logic               r_valid_wb;
    logic [OPC_W-1:0]   r_opc_ex;
    logic [OPC_W-1:0]   r_opc_wb;
    logic [REG_W-1:0]   r_rd_ex;
    logic [REG_W-1:0]   r_rd_wb;
    logic [ALUOP_W-1:0] r_alu_ex;

    logic       w_branch;
    logic       w_illegal;
    logic       w_stall;
    logic       w_ex_load;
    logic       w_ex_live;
    logic       w_valid_id_next;
    logic       w_pc_en;
    logic       w_ifid_en;
    logic       w_pc_sel;
    logic [1:0] w_rs_used;
    logic [1:0] w_ex_match;
    logic [1:0] w_wb_match;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_branch  = r_valid_ex && (r_opc_ex == OPC_BR);
    assign w_illegal = r_valid_id && (opcode_ID == OPC_ILL);
    assign w_rs_used = {opc_reads_rs2(opcode_ID), opc_reads_rs1(opcode_ID)};

    pipe_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .i_rs       ({rs2_ID, rs1_ID}),
        .i_rs_used  (w_rs_used),
        .i_valid_id (r_valid_id),
        .i_rd_ex    (r_rd_ex),
        .i_valid_ex (r_valid_ex),
        .i_wr_ex    (opc_writes(r_opc_ex)),
        .i_rd_wb    (r_rd_wb),
        .i_valid_wb (r_valid_wb),
        .i_wr_wb    (opc_writes(r_opc_wb)),
        .o_ex_match (w_ex_match),
        .o_wb_match (w_wb_match)
    );

`ifdef FWD_EN
    assign w_stall = 1'b0;
    assign w_fwd_a = fwd_select(w_ex_match[0], w_wb_match[0]);
    assign w_fwd_b = fwd_select(w_ex_match[1], w_wb_match[1]);
`else
    // Without a bypass network the consumer waits until its producer has left WB.
    assign w_stall = |(w_ex_match | w_wb_match);
    assign w_fwd_a = FWD_RF;
    assign w_fwd_b = FWD_RF;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_pc_en         = 1'b0;
        w_ifid_en       = 1'b0;
        w_pc_sel        = 1'b0;
        w_ex_load       = 1'b0;
        w_valid_id_next = r_valid_id;
        case (r_state)
            S_RUN: begin
                if (w_branch) begin
                    // The ID instruction and the word fetched this cycle are both squashed.
                    w_pc_sel        = 1'b1;
                    w_pc_en         = 1'b1;
                    w_ifid_en       = 1'b1;
                    w_valid_id_next = 1'b0;
                end else if (w_illegal) begin
                    w_state_next = S_HALT;
                end else if (!w_stall) begin
                    w_pc_en         = 1'b1;
                    w_ifid_en       = 1'b1;
                    w_ex_load       = 1'b1;
                    w_valid_id_next = fetch_valid;
                end
            end
            S_HALT: begin
                if (resume) begin
                    w_pc_en         = 1'b1;
                    w_ifid_en       = 1'b1;
                    w_valid_id_next = 1'b0;
                    w_state_next    = S_RUN;
                end
            end
            default: w_state_next = S_RUN;
        endcase
    end

    assign w_ex_live = w_ex_load && r_valid_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_valid_id <= 1'b0;
            r_valid_ex <= 1'b0;
            r_valid_wb <= 1'b0;
            r_opc_ex   <= '0;
            r_opc_wb   <= '0;
            r_rd_ex    <= '0;
            r_rd_wb    <= '0;
            r_alu_ex   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_valid_id <= w_valid_id_next;
            r_valid_ex <= w_ex_live;
            if (w_ex_live) begin
                r_opc_ex <= opcode_ID;
                r_rd_ex  <= rd_ID;
                r_alu_ex <= alu_code(opcode_ID);
            end else begin
                r_opc_ex <= '0;
                r_rd_ex  <= '0;
                r_alu_ex <= '0;
            end
            r_valid_wb <= r_valid_ex;
            r_opc_wb   <= r_opc_ex;
            r_rd_wb    <= r_rd_ex;
        end
    end

    // Combinational controls are forced low for the whole time reset is held.
    assign pc_en         = w_pc_en && !reset;
    assign ifid_en       = w_ifid_en && !reset;
    assign PC_Select     = w_pc_sel && !reset;
    assign fwd_A         = reset ? FWD_RF : w_fwd_a;
    assign fwd_B         = reset ? FWD_RF : w_fwd_b;
    assign halted        = (r_state == S_HALT) && !reset;
    assign valid_EX      = r_valid_ex;
    assign valid_WB      = r_valid_wb;
    assign ALU_Operation = r_alu_ex;
    assign Write_Reg_EX  = r_rd_ex;
    assign Write_Reg_WB  = r_rd_wb;
    assign RegWrite_WB   = r_valid_wb && opc_writes(r_opc_wb);

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Cycle table for pipeline_sequencer plus EX/WB scoreboards fed by the instructions the table advances.
module tb_pipeline_sequencer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_valid;
    logic       resume;
    logic [1:0] opcode_ID;
    logic [2:0] rs1_ID;
    logic [2:0] rs2_ID;
    logic [2:0] rd_ID;
    logic       pc_en;
    logic       ifid_en;
    logic       PC_Select;
    logic       valid_EX;
    logic       valid_WB;
    logic [3:0] ALU_Operation;
    logic       RegWrite_WB;
    logic [2:0] Write_Reg_EX;
    logic [2:0] Write_Reg_WB;
    logic [1:0] fwd_A;
    logic [1:0] fwd_B;
    logic       halted;

    always #5 clk = ~clk;

    pipeline_sequencer #(
        .OPC_W   (2),
        .REG_W   (3),
        .ALUOP_W (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .opcode_ID     (opcode_ID),
        .rs1_ID        (rs1_ID),
        .rs2_ID        (rs2_ID),
        .rd_ID         (rd_ID),
        .resume        (resume),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .PC_Select     (PC_Select),
        .valid_EX      (valid_EX),
        .valid_WB      (valid_WB),
        .ALU_Operation (ALU_Operation),
        .RegWrite_WB   (RegWrite_WB),
        .Write_Reg_EX  (Write_Reg_EX),
        .Write_Reg_WB  (Write_Reg_WB),
        .fwd_A         (fwd_A),
        .fwd_B         (fwd_B),
        .halted        (halted)
    );

    typedef struct packed {
        logic       rst;
        logic       fv;
        logic       res;
        logic [1:0] opc;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [2:0] rd;
        logic       pc;
        logic       ifid;
        logic       sel;
        logic       vex;
        logic       vwb;
        logic       rw;
        logic       hlt;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       adv;
    } vec_t;

    typedef struct packed {
        logic [2:0] rd;
        logic [3:0] alu;
    } ex_exp_t;

    typedef struct packed {
        logic [2:0] rd;
        logic       rw;
    } wb_exp_t;

    vec_t    tbl[$];
    string   names[$];
    ex_exp_t ex_q[$];
    wb_exp_t wb_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    function automatic logic [3:0] exp_alu(input logic [1:0] opc);
        return (opc == 2'b01) ? 4'b1000 : 4'b0010;
    endfunction

    task automatic add(input string nm, input logic rst, fv, res, input logic [1:0] opc,
                       input logic [2:0] rs1, rs2, rd, input logic pc, ifid, sel, vex, vwb, rw, hlt,
                       input logic [1:0] fa, fb, input logic adv);
        vec_t v;
        v = '{rst, fv, res, opc, rs1, rs2, rd, pc, ifid, sel, vex, vwb, rw, hlt, fa, fb, adv};
        tbl.push_back(v);
        names.push_back(nm);
    endtask

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, want %0h", nm, fld, act, exp);
        end
    endtask

    initial begin
        //   name        rst fv res opc    rs1   rs2   rd    pc ifid sel vex vwb rw hlt fa     fb     adv
        add("rst0",      H,  H, L,  2'b00, 3'd0, 3'd0, 3'd0, L, L,  L,  L,  L,  L, L,  2'b00, 2'b00, L);
        add("rst1",      H,  H, L,  2'b00, 3'd0, 3'd0, 3'd0, L, L,  L,  L,  L,  L, L,  2'b00, 2'b00, L);
        add("rst2",      H,  H, L,  2'b00, 3'd0, 3'd0, 3'd0, L, L,  L,  L,  L,  L, L,  2'b00, 2'b00, L);
        add("first",     L,  H, L,  2'b00, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  L,  L, L,  2'b00, 2'b00, L);
        add("add1",      L,  H, L,  2'b00, 3'd2, 3'd3, 3'd1, H, H,  L,  L,  L,  L, L,  2'b00, 2'b00, H);
`ifdef FWD_EN
        add("fwd_ex",    L,  L, L,  2'b00, 3'd1, 3'd1, 3'd4, H, H,  L,  H,  L,  L, L,  2'b01, 2'b01, H);
        add("fwd_drain", L,  L, L,  2'b00, 3'd0, 3'd0, 3'd0, H, H,  L,  H,  H,  H, L,  2'b00, 2'b00, L);
`else
        add("raw_ex",    L,  L, L,  2'b00, 3'd1, 3'd1, 3'd4, L, L,  L,  H,  L,  L, L,  2'b00, 2'b00, L);
        add("raw_wb",    L,  L, L,  2'b00, 3'd1, 3'd1, 3'd4, L, L,  L,  L,  H,  H, L,  2'b00, 2'b00, L);
        add("raw_go",    L,  L, L,  2'b00, 3'd1, 3'd1, 3'd4, H, H,  L,  L,  L,  L, L,  2'b00, 2'b00, H);
        add("add2_ex",   L,  L, L,  2'b00, 3'd0, 3'd0, 3'd0, H, H,  L,  H,  L,  L, L,  2'b00, 2'b00, L);
`endif
        add("add2_wb",   L,  H, L,  2'b00, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  H,  H, L,  2'b00, 2'b00, L);
        add("br_id",     L,  H, L,  2'b11, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  L,  L, L,  2'b00, 2'b00, H);
        add("br_ex",     L,  H, L,  2'b00, 3'd0, 3'd0, 3'd5, H, H,  H,  H,  L,  L, L,  2'b00, 2'b00, L);
        add("squash1",   L,  L, L,  2'b00, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  H,  L, L,  2'b00, 2'b00, L);
        add("squash2",   L,  H, L,  2'b00, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  L,  L, L,  2'b00, 2'b00, L);
        add("add6",      L,  H, L,  2'b00, 3'd0, 3'd0, 3'd6, H, H,  L,  L,  L,  L, L,  2'b00, 2'b00, H);
        add("ill_id",    L,  H, L,  2'b10, 3'd0, 3'd0, 3'd0, L, L,  L,  H,  L,  L, L,  2'b00, 2'b00, L);
        add("halt1",     L,  H, L,  2'b10, 3'd0, 3'd0, 3'd0, L, L,  L,  L,  H,  H, H,  2'b00, 2'b00, L);
        add("halt2",     L,  H, L,  2'b10, 3'd0, 3'd0, 3'd0, L, L,  L,  L,  L,  L, H,  2'b00, 2'b00, L);
        add("resume",    L,  H, H,  2'b10, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  L,  L, H,  2'b00, 2'b00, L);
        add("run",       L,  H, L,  2'b10, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  L,  L, L,  2'b00, 2'b00, L);
        add("br2_id",    L,  H, L,  2'b11, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  L,  L, L,  2'b00, 2'b00, H);
        add("br_vs_ill", L,  L, L,  2'b10, 3'd0, 3'd0, 3'd0, H, H,  H,  H,  L,  L, L,  2'b00, 2'b00, L);
        add("no_halt",   L,  H, L,  2'b00, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  H,  L, L,  2'b00, 2'b00, L);
        add("ill2",      L,  H, L,  2'b10, 3'd0, 3'd0, 3'd0, L, L,  L,  L,  L,  L, L,  2'b00, 2'b00, L);
        add("halt3",     L,  H, L,  2'b10, 3'd0, 3'd0, 3'd0, L, L,  L,  L,  L,  L, H,  2'b00, 2'b00, L);
        add("rst_halt",  H,  H, L,  2'b10, 3'd0, 3'd0, 3'd0, L, L,  L,  L,  L,  L, L,  2'b00, 2'b00, L);
        add("post_rst",  L,  L, L,  2'b10, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  L,  L, L,  2'b00, 2'b00, L);
        add("idle",      L,  L, L,  2'b00, 3'd0, 3'd0, 3'd0, H, H,  L,  L,  L,  L, L,  2'b00, 2'b00, L);

        reset       = 1'b1;
        fetch_valid = 1'b1;
        resume      = 1'b0;
        opcode_ID   = 2'b00;
        rs1_ID      = 3'd0;
        rs2_ID      = 3'd0;
        rd_ID       = 3'd0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t    v;
            ex_exp_t e;
            wb_exp_t w;
            v           = tbl[i];
            reset       = v.rst;
            fetch_valid = v.fv;
            resume      = v.res;
            opcode_ID   = v.opc;
            rs1_ID      = v.rs1;
            rs2_ID      = v.rs2;
            rd_ID       = v.rd;
            #1;
            chk(names[i], "pc_en",       16'(pc_en),       16'(v.pc));
            chk(names[i], "ifid_en",     16'(ifid_en),     16'(v.ifid));
            chk(names[i], "PC_Select",   16'(PC_Select),   16'(v.sel));
            chk(names[i], "valid_EX",    16'(valid_EX),    16'(v.vex));
            chk(names[i], "valid_WB",    16'(valid_WB),    16'(v.vwb));
            chk(names[i], "RegWrite_WB", 16'(RegWrite_WB), 16'(v.rw));
            chk(names[i], "halted",      16'(halted),      16'(v.hlt));
            chk(names[i], "fwd_A",       16'(fwd_A),       16'(v.fa));
            chk(names[i], "fwd_B",       16'(fwd_B),       16'(v.fb));
            if (v.rst)
                chk(names[i], "stage_fields", 16'({ALU_Operation, Write_Reg_EX, Write_Reg_WB}), 16'd0);

            if (valid_EX === 1'b1) begin
                if (ex_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s.ex_sb: got unexpected EX instruction rd=%0d, want none", names[i], Write_Reg_EX);
                end else begin
                    e = ex_q.pop_front();
                    chk(names[i], "Write_Reg_EX",  16'(Write_Reg_EX),  16'(e.rd));
                    chk(names[i], "ALU_Operation", 16'(ALU_Operation), 16'(e.alu));
                end
            end
            if (valid_WB === 1'b1) begin
                if (wb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s.wb_sb: got unexpected WB instruction rd=%0d, want none", names[i], Write_Reg_WB);
                end else begin
                    w = wb_q.pop_front();
                    chk(names[i], "Write_Reg_WB",    16'(Write_Reg_WB), 16'(w.rd));
                    chk(names[i], "RegWrite_WB_sb",  16'(RegWrite_WB),  16'(w.rw));
                end
            end
            if (v.adv) begin
                ex_q.push_back('{v.rd, exp_alu(v.opc)});
                wb_q.push_back('{v.rd, (v.opc != 2'b11)});
            end

            $display("[TB] cycle %-9s pc_en=%b ifid_en=%b PC_Select=%b vEX=%b vWB=%b RegWrite_WB=%b halted=%b fwd=%b/%b",
                     names[i], pc_en, ifid_en, PC_Select, valid_EX, valid_WB, RegWrite_WB, halted, fwd_A, fwd_B);
            @(posedge clk);
            #1;
        end

        chk("end", "ex_sb_left", 16'(ex_q.size()), 16'd0);
        chk("end", "wb_sb_left", 16'(wb_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
